multdiv_unit: RTL and testbench

//  Iterative signed 32-bit multiplier/divider for the execute stage of the 5-stage pipeline.

---
 rtl/multdiv_unit_pkg.sv | 30 +++
 rtl/multdiv_unit_booth_recoder.sv | 28 ++
 rtl/multdiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_multdiv_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_unit_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int          MULT_ITERS = 16;
   localparam int          DIV_ITERS  = 32;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   // Shared 34-bit add/subtract used by both the Booth and non-restoring steps
   function automatic logic [33:0] add_sub34(input logic [33:0] a,
                                             input logic [33:0] b,
                                             input logic        sub);
      logic [33:0] b_eff;
      b_eff = sub ? ~b : b;
      return a + b_eff + {33'd0, sub};
   endfunction

   // Magnitude of a two's complement word (INT_MIN maps to 0x80000000 unsigned)
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/multdiv_unit_booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to select lines.
module multdiv_unit_booth_recoder
(
   input  logic [2:0] i_window,
   output logic       o_zero,
   output logic       o_neg,
   output logic       o_two
);

   // Decode window {b[i+1], b[i], b[i-1]} into 0 / +-M / +-2M
   always_comb begin
      o_zero = 1'b0;
      o_neg  = 1'b0;
      o_two  = 1'b0;
      case (i_window)
         3'b000: o_zero = 1'b1;
         3'b001: o_neg  = 1'b0;
         3'b010: o_neg  = 1'b0;
         3'b011: o_two  = 1'b1;
         3'b100: begin o_two = 1'b1; o_neg = 1'b1; end
         3'b101: o_neg  = 1'b1;
         3'b110: o_neg  = 1'b1;
         3'b111: o_zero = 1'b1;
         default: o_zero = 1'b1;
      endcase
   end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiplier (radix-4 Booth) / divider (non-restoring).
module multdiv_unit
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [65:0]        r_prod;      // mult: {acc[33:0], multiplier}; div: [31:0] quotient
   logic               r_lsb;       // implicit Booth bit below the multiplier
   logic [33:0]        r_rem;       // signed partial remainder
   logic [31:0]        r_opd;       // multiplicand, or divisor magnitude
   logic               r_neg;       // quotient sign
   logic [WIDTH-1:0]   r_result;
   logic               r_exc;
   logic               r_rdy;
   logic               r_busy;

   logic               w_zero;
   logic               w_neg;
   logic               w_two;
   logic [33:0]        w_mcand;
   logic [33:0]        w_sel;
   logic [33:0]        w_acc;
   logic [65:0]        w_prod_next;
   logic [33:0]        w_shift;
   logic [33:0]        w_rem_next;
   logic [31:0]        w_quot_next;
   logic [31:0]        w_quot_fixed;
   logic               w_div_ovf;
   logic               w_mult_ovf;
   logic               w_mult_last;
   logic               w_div_last;
   logic               w_dvz;

   multdiv_unit_booth_recoder u_booth (
      .i_window (({r_prod[1:0], r_lsb})),
      .o_zero   (w_zero),
      .o_neg    (w_neg),
      .o_two    (w_two)
   );

   // Booth and non-restoring step datapath
   always_comb begin
      w_mcand = {{2{r_opd[31]}}, r_opd};
      if (w_zero) begin
         w_sel = 34'd0;
      end else if (w_two) begin
         w_sel = {w_mcand[32:0], 1'b0};
      end else begin
         w_sel = w_mcand;
      end
      w_acc       = add_sub34(r_prod[65:32], w_sel, w_neg);
      w_prod_next = {{2{w_acc[33]}}, w_acc, r_prod[31:2]};
      w_mult_ovf  = (w_prod_next[63:32] != {32{w_prod_next[31]}});

      // Shift in next dividend bit; subtract when remainder non-negative, else add
      w_shift      = {r_rem[32:0], r_prod[31]};
      w_rem_next   = add_sub34(w_shift, {2'b00, r_opd}, ~r_rem[33]);
      w_quot_next  = {r_prod[30:0], ~w_rem_next[33]};
      w_quot_fixed = r_neg ? (32'd0 - w_quot_next) : w_quot_next;
      w_div_ovf    = ~r_neg & w_quot_next[31];

      w_mult_last = (r_cnt == CNT_W'(MULT_ITERS - 1));
      w_div_last  = (r_cnt == CNT_W'(DIV_ITERS - 1));
      w_dvz       = (r_opd == 32'd0);
   end

   // Next-state logic; a start in any state (MULT priority) restarts the unit
   always_comb begin
      w_state_next = r_state;
      if (ctrl_MULT) begin
         w_state_next = ST_MULT;
      end else if (ctrl_DIV) begin
         w_state_next = ST_DIV;
      end else begin
         case (r_state)
            ST_IDLE: w_state_next = ST_IDLE;
            ST_MULT: w_state_next = w_mult_last ? ST_DONE : ST_MULT;
            ST_DIV:  w_state_next = (w_dvz || w_div_last) ? ST_DONE : ST_DIV;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Operand latch, iteration registers and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_prod   <= 66'd0;
         r_lsb    <= 1'b0;
         r_rem    <= 34'd0;
         r_opd    <= 32'd0;
         r_neg    <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
         r_rdy    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         if (ctrl_MULT || ctrl_DIV) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_lsb  <= 1'b0;
            r_rem  <= 34'd0;
            if (ctrl_MULT) begin
               r_prod <= {34'd0, data_operandB};
               r_opd  <= data_operandA;
               r_neg  <= 1'b0;
            end else begin
               r_prod <= {34'd0, abs32(data_operandA)};
               r_opd  <= abs32(data_operandB);
               r_neg  <= data_operandA[31] ^ data_operandB[31];
            end
         end else begin
            case (r_state)
               ST_MULT: begin
                  r_prod <= w_prod_next;
                  r_lsb  <= r_prod[1];
                  r_cnt  <= r_cnt + CNT_W'(1);
                  if (w_mult_last) begin
                     r_result <= w_prod_next[31:0];
                     r_exc    <= w_mult_ovf;
                     r_rdy    <= 1'b1;
                     r_busy   <= 1'b0;
                  end
               end
               ST_DIV: begin
                  if (w_dvz) begin
                     r_result <= '0;
                     r_exc    <= 1'b1;
                     r_rdy    <= 1'b1;
                     r_busy   <= 1'b0;
                  end else begin
                     r_rem         <= w_rem_next;
                     r_prod[31:0]  <= w_quot_next;
                     r_cnt         <= r_cnt + CNT_W'(1);
                     if (w_div_last) begin
                        r_result <= w_quot_fixed;
                        r_exc    <= w_div_ovf;
                        r_rdy    <= 1'b1;
                        r_busy   <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = r_rdy;
   assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes expectations, monitor pops on RDY.
module tb_multdiv_unit;

   typedef struct {
      int          tag;
      logic [31:0] res;
      logic        exc;
      int          lat;
      int          start;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = 32'd0;
   logic [31:0] data_operandB = 32'd0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV  = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   exp_t sb_q[$];
   int   cyc     = 0;
   int   total   = 0;
   int   bad     = 0;
   int   rdy_cnt = 0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp_v);
      end
   endtask

   // Monitor: every RDY strobe must match the oldest expectation
   always @(negedge clock) begin
      if (!reset && data_resultRDY) begin
         rdy_cnt++;
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rdy: got strobe at cycle %0d want none", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("op%0d_result", e.tag), data_result, e.res);
            chk($sformatf("op%0d_exc", e.tag), {31'd0, data_exception}, {31'd0, e.exc});
            chk($sformatf("op%0d_latency", e.tag), cyc - e.start, e.lat);
            chk($sformatf("op%0d_busy", e.tag), {31'd0, busy}, 32'd0);
         end
      end
   end

   // Pulse a start for one cycle; optionally register the expected completion
   task automatic start_op(input int tag, input logic m, input logic d,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic push, input logic [31:0] res,
                           input logic exc, input int lat);
      exp_t e;
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      if (push) begin
         e.tag = tag; e.res = res; e.exc = exc; e.lat = lat; e.start = cyc + 1;
         sb_q.push_back(e);
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      chk($sformatf("op%0d_busy_after_start", tag), {31'd0, busy}, 32'd1);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      int seen;
      repeat (3) @(negedge clock);
      chk("reset_result", data_result, 32'd0);
      chk("reset_exc",    {31'd0, data_exception}, 32'd0);
      chk("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);
      chk("reset_busy",   {31'd0, busy}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      start_op(1, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0, 16);
      drain(40);
      start_op(2, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 1'b1, 16);
      drain(40);
      start_op(3, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b1, 32'd30, 1'b0, 16);
      drain(40);
      start_op(4, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 1'b1, 16);
      drain(40);
      start_op(5, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 1'b1, 16);
      drain(40);
      start_op(6, 1'b1, 1'b1, 32'd6, 32'd3, 1'b1, 32'd18, 1'b0, 16);
      drain(40);
      start_op(7, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0, 32);
      drain(60);
      start_op(8, 1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1, 1);
      drain(10);
      start_op(9, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 32);
      drain(60);
      start_op(10, 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0, 32);
      drain(60);
      start_op(11, 1'b0, 1'b1, 32'd0, 32'd5, 1'b1, 32'd0, 1'b0, 32);
      drain(60);
      start_op(12, 1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 32);
      drain(60);

      // Reset mid-multiply: outputs clear at once and no strobe follows
      start_op(13, 1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, 0);
      repeat (7) @(negedge clock);
      seen = rdy_cnt;
      reset = 1'b1;
      #1;
      chk("midreset_result", data_result, 32'd0);
      chk("midreset_exc",    {31'd0, data_exception}, 32'd0);
      chk("midreset_busy",   {31'd0, busy}, 32'd0);
      chk("midreset_rdy",    {31'd0, data_resultRDY}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (30) @(negedge clock);
      chk("midreset_no_strobe", rdy_cnt, seen);

      // Divide aborted by a multiply: only the multiply completes
      start_op(14, 1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 0);
      repeat (8) @(negedge clock);
      seen = rdy_cnt;
      start_op(15, 1'b1, 1'b0, 32'd6, 32'd6, 1'b1, 32'd36, 1'b0, 16);
      drain(40);
      repeat (40) @(negedge clock);
      chk("abort_single_strobe", rdy_cnt - seen, 32'd1);
      chk("idle_hold_result", data_result, 32'd36);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule
